// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer: per-cycle advance/stall/flush control for fetch and decode.
// Optional perf counters are built when HAZ_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int AWIDTH       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int LOAD_STALL   = 1,
    parameter int CWIDTH       = 16
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              h_i_d_valid,
    input  logic [AWIDTH-1:0] h_i_d_rs1,
    input  logic [AWIDTH-1:0] h_i_d_rs2,
    input  logic              h_i_x_valid,
    input  logic [AWIDTH-1:0] h_i_x_rd,
    input  logic              h_i_x_is_load,
    input  logic              h_i_x_redirect,
    input  logic              h_i_m_busy,
    output logic              h_o_f_stall,
    output logic              h_o_d_stall,
    output logic              h_o_d_flush,
    output logic              h_o_x_flush,
    output logic              h_o_d_ce,
    output logic [1:0]        h_o_state,
    output logic [CWIDTH-1:0] h_o_stall_cnt,
    output logic [CWIDTH-1:0] h_o_flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_FLUSH   = 2'd2,
        S_MEMWAIT = 2'd3
    } state_t;

    // The event cycle itself is the first stall/flush cycle, so the counter holds the remainder.
    localparam logic [3:0] LP_FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] LP_STALL_RELOAD = 4'(LOAD_STALL - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_cnt_dec;
    logic       r_pend;
    logic       w_pend_nxt;
    logic       w_hazard;
    logic       w_redir_eff;
    logic       w_f_stall;
    logic       w_d_stall;
    logic       w_d_flush;
    logic       w_x_flush;
    logic       w_d_ce;

    assign w_hazard    = h_i_d_valid & h_i_x_valid & h_i_x_is_load & (h_i_x_rd != '0) &
                         ((h_i_x_rd == h_i_d_rs1) | (h_i_x_rd == h_i_d_rs2));
    // A redirect parked during memory back-pressure is replayed as if it arrived now.
    assign w_redir_eff = h_i_x_redirect | r_pend;
    assign w_cnt_dec   = r_cnt - 4'd1;

    always_ff @(posedge h_clk or posedge h_rst) begin
        if (h_rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = 1'b0;
        w_f_stall   = 1'b0;
        w_d_stall   = 1'b0;
        w_d_flush   = 1'b0;
        w_x_flush   = 1'b0;
        w_d_ce      = 1'b1;
        case (r_state)
            S_RUN, S_MEMWAIT: begin
                if (h_i_m_busy) begin
                    w_f_stall   = 1'b1;
                    w_d_stall   = 1'b1;
                    w_d_ce      = 1'b0;
                    w_state_nxt = S_MEMWAIT;
                    w_pend_nxt  = w_redir_eff;
                end else if (w_redir_eff) begin
                    w_d_flush = 1'b1;
                    w_x_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = LP_FLUSH_RELOAD;
                    end
                end else if (w_hazard) begin
                    w_f_stall = 1'b1;
                    w_d_stall = 1'b1;
                    w_x_flush = 1'b1;
                    if (LOAD_STALL > 1) begin
                        w_state_nxt = S_LDSTALL;
                        w_cnt_nxt   = LP_STALL_RELOAD;
                    end
                end
            end
            S_LDSTALL: begin
                if (h_i_m_busy) begin
                    w_f_stall   = 1'b1;
                    w_d_stall   = 1'b1;
                    w_d_ce      = 1'b0;
                    w_state_nxt = S_MEMWAIT;
                    w_pend_nxt  = h_i_x_redirect;
                end else if (h_i_x_redirect) begin
                    w_d_flush = 1'b1;
                    w_x_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = S_FLUSH;
                        w_cnt_nxt   = LP_FLUSH_RELOAD;
                    end
                end else begin
                    w_f_stall = 1'b1;
                    w_d_stall = 1'b1;
                    w_x_flush = 1'b1;
                    w_cnt_nxt = w_cnt_dec;
                    if (w_cnt_dec != 4'd0) begin
                        w_state_nxt = S_LDSTALL;
                    end
                end
            end
            S_FLUSH: begin
                if (h_i_m_busy) begin
                    // The interrupted squash window restarts in full once memory is ready.
                    w_f_stall   = 1'b1;
                    w_d_stall   = 1'b1;
                    w_d_ce      = 1'b0;
                    w_state_nxt = S_MEMWAIT;
                    w_pend_nxt  = 1'b1;
                end else begin
                    w_d_flush = 1'b1;
                    w_x_flush = 1'b1;
                    if (h_i_x_redirect) begin
                        if (FLUSH_CYCLES > 1) begin
                            w_state_nxt = S_FLUSH;
                            w_cnt_nxt   = LP_FLUSH_RELOAD;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                        if (w_cnt_dec != 4'd0) begin
                            w_state_nxt = S_FLUSH;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
        if (h_rst) begin
            w_f_stall = 1'b0;
            w_d_stall = 1'b0;
            w_d_flush = 1'b1;
            w_x_flush = 1'b1;
            w_d_ce    = 1'b0;
        end
    end

    assign h_o_f_stall = w_f_stall;
    assign h_o_d_stall = w_d_stall;
    assign h_o_d_flush = w_d_flush;
    assign h_o_x_flush = w_x_flush;
    assign h_o_d_ce    = w_d_ce;
    assign h_o_state   = r_state;

`ifdef HAZ_PERF_EN
    logic [CWIDTH-1:0] r_stall_cnt;
    logic [CWIDTH-1:0] r_flush_cnt;

    always_ff @(posedge h_clk or posedge h_rst) begin
        if (h_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_d_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CWIDTH'(1);
            end
            if (h_i_x_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CWIDTH'(1);
            end
        end
    end

    assign h_o_stall_cnt = r_stall_cnt;
    assign h_o_flush_cnt = r_flush_cnt;
`else
    assign h_o_stall_cnt = '0;
    assign h_o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand sequences and random stimulus vs. a
// priority-list reference model; two instances (LOAD_STALL=1 and LOAD_STALL=3).
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 5;
    localparam int CW   = 16;
    localparam int FC   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          h_clk = 1'b0;
    logic          h_rst;
    logic          d_valid;
    logic [AW-1:0] d_rs1;
    logic [AW-1:0] d_rs2;
    logic          x_valid;
    logic [AW-1:0] x_rd;
    logic          x_is_load;
    logic          x_redirect;
    logic          m_busy;

    logic [1:0]    f_stall, d_stall, d_flush, x_flush, d_ce;
    logic [1:0]    st0, st1;
    logic [CW-1:0] scnt0, scnt1, fcnt0, fcnt1;

    int checks = 0;
    int errors = 0;

    // reference model: remaining flush / stall cycles, memory-wait flag, parked redirect
    int m_fl[2];
    int m_sl[2];
    bit m_mem[2];
    bit m_pend[2];
    int m_sc[2];
    int m_fc[2];
    int m_ls[2];

    typedef struct {
        logic          rst;
        logic          dv;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          xv;
        logic [AW-1:0] rd;
        logic          ld;
        logic          redir;
        logic          busy;
        logic [6:0]    exp;
    } vec_t;

    vec_t tab[22];

    pipeline_hazard_ctrl #(.AWIDTH(AW), .FLUSH_CYCLES(FC), .LOAD_STALL(1), .CWIDTH(CW)) u_dut (
        .h_clk(h_clk), .h_rst(h_rst),
        .h_i_d_valid(d_valid), .h_i_d_rs1(d_rs1), .h_i_d_rs2(d_rs2),
        .h_i_x_valid(x_valid), .h_i_x_rd(x_rd), .h_i_x_is_load(x_is_load),
        .h_i_x_redirect(x_redirect), .h_i_m_busy(m_busy),
        .h_o_f_stall(f_stall[0]), .h_o_d_stall(d_stall[0]), .h_o_d_flush(d_flush[0]),
        .h_o_x_flush(x_flush[0]), .h_o_d_ce(d_ce[0]), .h_o_state(st0),
        .h_o_stall_cnt(scnt0), .h_o_flush_cnt(fcnt0)
    );

    pipeline_hazard_ctrl #(.AWIDTH(AW), .FLUSH_CYCLES(FC), .LOAD_STALL(3), .CWIDTH(CW)) u_dut_ls3 (
        .h_clk(h_clk), .h_rst(h_rst),
        .h_i_d_valid(d_valid), .h_i_d_rs1(d_rs1), .h_i_d_rs2(d_rs2),
        .h_i_x_valid(x_valid), .h_i_x_rd(x_rd), .h_i_x_is_load(x_is_load),
        .h_i_x_redirect(x_redirect), .h_i_m_busy(m_busy),
        .h_o_f_stall(f_stall[1]), .h_o_d_stall(d_stall[1]), .h_o_d_flush(d_flush[1]),
        .h_o_x_flush(x_flush[1]), .h_o_d_ce(d_ce[1]), .h_o_state(st1),
        .h_o_stall_cnt(scnt1), .h_o_flush_cnt(fcnt1)
    );

    always #5 h_clk = ~h_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] pack(input int i);
        if (i == 0) return {f_stall[0], d_stall[0], d_flush[0], x_flush[0], d_ce[0], st0};
        return {f_stall[1], d_stall[1], d_flush[1], x_flush[1], d_ce[1], st1};
    endfunction

    function automatic vec_t mk(input logic rst, input logic dv, input int rs1, input int rs2,
                                input logic xv, input int rd, input logic ld, input logic redir,
                                input logic busy, input logic [6:0] exp);
        vec_t v;
        v.rst = rst; v.dv = dv; v.rs1 = AW'(rs1); v.rs2 = AW'(rs2);
        v.xv = xv; v.rd = AW'(rd); v.ld = ld; v.redir = redir; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        h_rst = v.rst; d_valid = v.dv; d_rs1 = v.rs1; d_rs2 = v.rs2;
        x_valid = v.xv; x_rd = v.rd; x_is_load = v.ld; x_redirect = v.redir; m_busy = v.busy;
    endtask

    // Outputs packed as {f_stall, d_stall, d_flush, x_flush, d_ce, state[1:0]}.
    task automatic model_step(input int i, output logic [6:0] exp);
        logic [4:0] o;
        logic [1:0] st;
        bit haz;
        haz = d_valid && x_valid && x_is_load && (x_rd != 0) && (x_rd == d_rs1 || x_rd == d_rs2);
        if (h_rst) begin
            m_fl[i] = 0; m_sl[i] = 0; m_mem[i] = 0; m_pend[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            exp = 7'b0011000;
            return;
        end
        st = m_mem[i] ? 2'd3 : (m_fl[i] > 0) ? 2'd2 : (m_sl[i] > 0) ? 2'd1 : 2'd0;
        if (m_busy) begin
            o = 5'b11000;
            m_pend[i] = m_pend[i] || x_redirect || (m_fl[i] > 0);
            m_fl[i] = 0; m_sl[i] = 0; m_mem[i] = 1;
        end else begin
            m_mem[i] = 0;
            if (x_redirect || m_pend[i]) begin
                o = 5'b00111; m_fl[i] = FC - 1; m_sl[i] = 0; m_pend[i] = 0;
            end else if (m_fl[i] > 0) begin
                o = 5'b00111; m_fl[i]--;
            end else if (m_sl[i] > 0) begin
                o = 5'b11011; m_sl[i]--;
            end else if (haz) begin
                o = 5'b11011; m_sl[i] = m_ls[i] - 1;
            end else begin
                o = 5'b00001;
            end
        end
        if (o[3] && m_sc[i] < CMAX) m_sc[i]++;
        if (x_redirect && m_fc[i] < CMAX) m_fc[i]++;
        exp = {o, st};
    endtask

    task automatic tick(input logic [6:0] e0, input logic [6:0] e1, input bit c0, input bit c1,
                        input string nm);
        logic [6:0] e;
        logic [CW-1:0] sc_act, fc_act;
        @(negedge h_clk);
        for (int i = 0; i < 2; i++) begin
            model_step(i, e);
            check($sformatf("%s model dut%0d", nm, i), 32'(pack(i)), 32'(e));
            sc_act = (i == 0) ? scnt0 : scnt1;
            fc_act = (i == 0) ? fcnt0 : fcnt1;
`ifdef HAZ_PERF_EN
            check($sformatf("%s stall_cnt dut%0d", nm, i), 32'(sc_act), 32'(m_sc[i]));
            check($sformatf("%s flush_cnt dut%0d", nm, i), 32'(fc_act), 32'(m_fc[i]));
`else
            check($sformatf("%s stall_cnt dut%0d", nm, i), 32'(sc_act), 32'd0);
            check($sformatf("%s flush_cnt dut%0d", nm, i), 32'(fc_act), 32'd0);
`endif
        end
        if (c0) check($sformatf("%s vec dut0", nm), 32'(pack(0)), 32'(e0));
        if (c1) check($sformatf("%s vec dut1", nm), 32'(pack(1)), 32'(e1));
        @(posedge h_clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_s, exp_f;
        vec_t idle, v;
        m_ls[0] = 1;
        m_ls[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_fl[i] = 0; m_sl[i] = 0; m_mem[i] = 0; m_pend[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000100);

        tab[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011000);
        tab[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011000);
        tab[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011000);
        tab[3]  = idle;
        tab[4]  = mk(0, 1, 9, 3, 1, 9, 1, 0, 0, 7'b1101100);  // lw x9 feeding rs1
        tab[5]  = idle;
        tab[6]  = mk(0, 1, 0, 4, 1, 0, 1, 0, 0, 7'b0000100);  // x0 never hazards
        tab[7]  = mk(0, 1, 9, 0, 0, 9, 1, 0, 0, 7'b0000100);
        tab[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0011100);
        tab[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011110);
        tab[10] = idle;
        tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1100000);
        tab[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1100011);
        tab[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1100011);
        tab[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b1100011);
        tab[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011111);
        tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011110);
        tab[17] = idle;
        tab[18] = mk(0, 1, 2, 5, 1, 5, 1, 0, 0, 7'b1101100);  // match on rs2
        tab[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0011100);
        tab[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0011000);  // reset aborts the flush
        tab[21] = idle;

        set_in(tab[0]);
        @(posedge h_clk);
        #1;
        for (int k = 0; k < 22; k++) begin
            set_in(tab[k]);
            tick(tab[k].exp, 7'd0, 1'b1, 1'b0, $sformatf("vec%0d", k));
        end

        // redirect arriving in the 2nd cycle of a 3-cycle load-use stall (dut1)
        set_in(mk(0, 1, 9, 0, 1, 9, 1, 0, 0, 7'd0));
        tick(7'b1101100, 7'b1101100, 1'b1, 1'b1, "ldr_c1");
        set_in(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'd0));
        tick(7'b0011100, 7'b0011101, 1'b1, 1'b1, "ldr_c2");
        set_in(idle);
        tick(7'b0011110, 7'b0011110, 1'b1, 1'b1, "ldr_c3");
        tick(7'b0000100, 7'b0000100, 1'b1, 1'b1, "ldr_c4");

        // perf counters: 3 hazards + 2 redirects on dut0
        set_in(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0));
        tick(7'b0011000, 7'b0011000, 1'b1, 1'b1, "perf_rst");
        for (int k = 0; k < 3; k++) begin
            set_in(mk(0, 1, 7, 7, 1, 7, 1, 0, 0, 7'd0));
            tick(7'b1101100, 7'd0, 1'b1, 1'b0, $sformatf("perf_haz%0d", k));
            set_in(idle);
            tick(7'b0000100, 7'd0, 1'b1, 1'b0, $sformatf("perf_gap%0d", k));
            tick(7'd0, 7'd0, 1'b0, 1'b0, "perf_gap_b");
        end
        for (int k = 0; k < 2; k++) begin
            set_in(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'd0));
            tick(7'b0011100, 7'd0, 1'b1, 1'b0, $sformatf("perf_red%0d", k));
            set_in(idle);
            tick(7'b0011110, 7'd0, 1'b1, 1'b0, $sformatf("perf_fl%0d", k));
            tick(7'b0000100, 7'd0, 1'b1, 1'b0, $sformatf("perf_run%0d", k));
        end
`ifdef HAZ_PERF_EN
        exp_s = 32'd3;
        exp_f = 32'd2;
`else
        exp_s = 32'd0;
        exp_f = 32'd0;
`endif
        check("perf stall_cnt", 32'(scnt0), exp_s);
        check("perf flush_cnt", 32'(fcnt0), exp_f);
        set_in(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'd0));
        tick(7'b0011000, 7'b0011000, 1'b1, 1'b1, "perf_clr");
        check("perf stall_cnt cleared", 32'(scnt0), 32'd0);
        check("perf flush_cnt cleared", 32'(fcnt0), 32'd0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            v.rst   = ($urandom_range(99) == 0);
            v.dv    = $urandom_range(1);
            v.rs1   = AW'($urandom_range(3));
            v.rs2   = AW'($urandom_range(3));
            v.xv    = $urandom_range(1);
            v.rd    = AW'($urandom_range(3));
            v.ld    = $urandom_range(1);
            v.redir = ($urandom_range(6) == 0);
            v.busy  = ($urandom_range(5) == 0);
            v.exp   = 7'd0;
            set_in(v);
            tick(7'd0, 7'd0, 1'b0, 1'b0, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
